sd_read_arbiter: RTL and testbench

Shares the single SPI SD-card block reader between NREQ requesters, e.g. the cartridge PRG loader and the CHR loader. It takes sector-number requests and grants the reader round-robin. It converts each sector number to a byte address and issues a one-cycle begin to the reader. It then counts the 512-byte data stream, routes it to the granted requester, and ends the transfer with done, or with err on timeout or short transfer.

---
 rtl/sd_pkg.sv | 21 ++
 rtl/sd_read_arbiter_if.sv | 30 +++
 rtl/sd_read_arbiter_rr_pick.sv | 27 ++
 rtl/sd_read_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sd_read_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD reader/arbiter types and command constants
package sd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_STREAM = 3'd3,
      ST_FINISH = 3'd4,
      ST_ABORT  = 3'd5
   } arb_state_t;

   localparam int SD_BLOCK_BYTES = 512;

   localparam logic [7:0] SD_CMD0       = 8'h40;
   localparam logic [7:0] SD_CMD1       = 8'h41;
   localparam logic [7:0] SD_CMD17      = 8'h51;
   localparam logic [7:0] SD_CRC0       = 8'h95;
   localparam logic [7:0] SD_DATA_TOKEN = 8'hFE;

endpackage

// File: rtl/sd_read_arbiter_if.sv
// rtl/sd_read_arbiter_if.sv - requester and block-reader signals of the read arbiter
interface sd_read_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]      req;
   logic [32*NREQ-1:0]   req_sector;
   logic [NREQ-1:0]      gnt;
   logic [7:0]           rd_byte;
   logic [NREQ-1:0]      rd_valid;
   logic [NREQ-1:0]      rd_done;
   logic [NREQ-1:0]      rd_err;
   logic                 sd_idle;
   logic                 sd_begin;
   logic [31:0]          sd_addr;
   logic                 sd_active;
   logic                 sd_byte_valid;
   logic [7:0]           sd_byte;

   // arbiter side
   modport slave (
      input  req, req_sector, sd_idle, sd_active, sd_byte_valid, sd_byte,
      output gnt, rd_byte, rd_valid, rd_done, rd_err, sd_begin, sd_addr
   );

   // requesters plus block reader side
   modport master (
      output req, req_sector, sd_idle, sd_active, sd_byte_valid, sd_byte,
      input  gnt, rd_byte, rd_valid, rd_done, rd_err, sd_begin, sd_addr
   );
endinterface

// File: rtl/sd_read_arbiter_rr_pick.sv
// rtl/sd_read_arbiter_rr_pick.sv - combinational round-robin requester selector
module rr_pick #(
   parameter int NREQ  = 2,
   parameter int PTR_W = 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  sel,
   output logic             valid
);

   // scan offsets from the far end down so the nearest set bit at or after ptr wins
   always_comb begin
      sel = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         for (int j = 0; j < NREQ; j++) begin
            if (req[j] && (((int'(ptr) + k) % NREQ) == j)) begin
               sel    = '0;
               sel[j] = 1'b1;
            end
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/sd_read_arbiter.sv
// rtl/sd_read_arbiter.sv - round-robin sharing of one SD block reader between requesters
module sd_read_arbiter
   import sd_pkg::*;
#(
   parameter int NREQ           = 2,
   parameter int ADDR_SHIFT     = 9,
   parameter int BLOCK_BYTES    = SD_BLOCK_BYTES,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input logic              clock,
   input logic              reset,
   sd_read_arbiter_if.slave bus
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(BLOCK_BYTES) + 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_t        state;
   arb_state_t        state_next;
   logic [NREQ-1:0]   pick_sel;
   logic              pick_valid;
   logic [31:0]       pick_sector;
   logic [NREQ-1:0]   gnt_q;
   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  gnt_idx;
   logic [PTR_W-1:0]  ptr_after;
   logic [31:0]       addr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [TMR_W-1:0]  tmr_q;
   logic [7:0]        rd_byte_q;
   logic [NREQ-1:0]   rd_valid_q;
   logic [NREQ-1:0]   rd_done_q;
   logic [NREQ-1:0]   rd_err_q;
   logic              grant_load;
   logic              byte_take;
   logic              byte_last;
   logic              timed_out;
   logic              begin_c;

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .sel   (pick_sel),
      .valid (pick_valid)
   );

   // sector lane of the requester the picker would grant
   always_comb begin
      pick_sector = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (pick_sel[j]) pick_sector = bus.req_sector[32*j +: 32];
      end
   end

   // next pointer sits just past the requester currently holding the grant
   always_comb begin
      gnt_idx = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (gnt_q[j]) gnt_idx = PTR_W'(j);
      end
      ptr_after = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
   end

   // state register
   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // next state and per-cycle controls; completion beats a same-cycle drop of sd_active
   always_comb begin
      state_next = state;
      grant_load = 1'b0;
      byte_take  = 1'b0;
      begin_c    = 1'b0;
      byte_last  = (cnt_q == CNT_W'(BLOCK_BYTES - 1));
      timed_out  = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
      case (state)
         ST_IDLE: begin
            if (bus.sd_idle && pick_valid) begin
               grant_load = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            begin_c    = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.sd_active) begin
               byte_take = bus.sd_byte_valid;
               if (bus.sd_byte_valid && byte_last) state_next = ST_FINISH;
               else if (timed_out)                 state_next = ST_ABORT;
               else                                state_next = ST_STREAM;
            end else if (timed_out) begin
               state_next = ST_ABORT;
            end
         end
         ST_STREAM: begin
            byte_take = bus.sd_byte_valid;
            if (bus.sd_byte_valid && byte_last)   state_next = ST_FINISH;
            else if (!bus.sd_active || timed_out) state_next = ST_ABORT;
         end
         ST_FINISH: state_next = ST_IDLE;
         ST_ABORT:  state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // grant, address, counters and the registered requester-side strobes
   always_ff @(posedge clock) begin
      if (reset) begin
         gnt_q      <= '0;
         ptr_q      <= '0;
         addr_q     <= '0;
         cnt_q      <= '0;
         tmr_q      <= '0;
         rd_byte_q  <= '0;
         rd_valid_q <= '0;
         rd_done_q  <= '0;
         rd_err_q   <= '0;
      end else begin
         rd_valid_q <= '0;
         rd_done_q  <= '0;
         rd_err_q   <= '0;
         if (grant_load) begin
            gnt_q  <= pick_sel;
            addr_q <= pick_sector << ADDR_SHIFT;
            cnt_q  <= '0;
            tmr_q  <= '0;
         end else if (state != ST_IDLE) begin
            tmr_q <= tmr_q + TMR_W'(1);
         end
         if (byte_take) begin
            rd_byte_q  <= bus.sd_byte;
            rd_valid_q <= gnt_q;
            cnt_q      <= cnt_q + CNT_W'(1);
         end
         if (state == ST_FINISH) begin
            rd_done_q <= gnt_q;
            gnt_q     <= '0;
            ptr_q     <= ptr_after;
         end
         if (state == ST_ABORT) begin
            rd_err_q <= gnt_q;
            gnt_q    <= '0;
            ptr_q    <= ptr_after;
         end
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.sd_addr  = addr_q;
   assign bus.sd_begin = begin_c;
   assign bus.rd_byte  = rd_byte_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_done  = rd_done_q;
   assign bus.rd_err   = rd_err_q;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// tb/tb_sd_read_arbiter.sv - directed self-checking bench for sd_read_arbiter
module tb_sd_read_arbiter;

   localparam int NREQ = 2;

   typedef struct {
      logic [1:0]  req;
      logic [31:0] sector;
      int          nsend;
      logic [31:0] addr;
      int          exp_valid;
      int          exp_done;
      int          exp_err;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   sd_read_arbiter_if #(.NREQ(NREQ)) bus ();
   sd_read_arbiter_if #(.NREQ(NREQ)) tbus ();

   sd_read_arbiter #(
      .NREQ(NREQ), .ADDR_SHIFT(9), .BLOCK_BYTES(512), .TIMEOUT_CYCLES(4096)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   sd_read_arbiter #(
      .NREQ(NREQ), .ADDR_SHIFT(9), .BLOCK_BYTES(512), .TIMEOUT_CYCLES(64)
   ) dut_to (
      .clock (clock),
      .reset (reset),
      .bus   (tbus)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int valid_total = 0;
   int valid_base = 0;
   int done_total = 0;
   int err_total = 0;
   int begin_total = 0;
   int data_err = 0;
   int lane_err = 0;
   int multihot = 0;
   int last_valid_cyc = 0;
   int done_cyc = 0;
   int t_done_total = 0;
   logic [1:0] exp_lane = 2'b00;
   vec_t vecs[4];

   always @(negedge clock) begin
      cyc = cyc + 1;
      if (|bus.rd_valid) begin
         if (bus.rd_byte !== 8'(valid_total - valid_base)) data_err = data_err + 1;
         if (bus.rd_valid !== exp_lane) lane_err = lane_err + 1;
         valid_total = valid_total + 1;
         last_valid_cyc = cyc;
      end
      if (|bus.rd_done) begin
         if (bus.rd_done !== exp_lane) lane_err = lane_err + 1;
         done_total = done_total + 1;
         done_cyc = cyc;
      end
      if (|bus.rd_err) begin
         if (bus.rd_err !== exp_lane) lane_err = lane_err + 1;
         err_total = err_total + 1;
      end
      if (bus.sd_begin === 1'b1) begin_total = begin_total + 1;
      if (|tbus.rd_done) t_done_total = t_done_total + 1;
      if ($countones(bus.gnt) > 1 || $countones(bus.rd_valid) > 1 ||
          $countones(bus.rd_done) > 1 || $countones(bus.rd_err) > 1 ||
          $countones(tbus.gnt) > 1 || $countones(tbus.rd_err) > 1)
         multihot = multihot + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_begin(output int waited);
      waited = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock);
         if (bus.sd_begin === 1'b1) begin
            waited = i;
            break;
         end
      end
   endtask

   task automatic stream(input int n, input logic [1:0] drop);
      bus.sd_active = 1'b1;
      bus.sd_idle   = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         bus.sd_byte_valid = 1'b1;
         bus.sd_byte       = 8'(i);
      end
      @(negedge clock);
      bus.sd_byte_valid = 1'b0;
      bus.sd_active     = 1'b0;
      bus.req           = bus.req & ~drop;
   endtask

   task automatic serve(input logic [1:0] lane, input logic [31:0] addr, input int n,
                        input logic [1:0] drop, input int exp_valid, input int exp_done,
                        input int exp_err, input string name, output int waited);
      int b_begin, b_valid, b_done, b_err;
      b_begin  = begin_total;
      b_done   = done_total;
      b_err    = err_total;
      exp_lane = lane;
      bus.sd_idle = 1'b1;
      wait_begin(waited);
      check({name, " begin seen"}, 64'(waited > 0), 64'd1);
      valid_base = valid_total;
      b_valid    = valid_total;
      check({name, " gnt"}, 64'(bus.gnt), 64'(lane));
      check({name, " sd_addr"}, 64'(bus.sd_addr), 64'(addr));
      stream(n, drop);
      repeat (4) @(negedge clock);
      check({name, " begin pulses"}, 64'(begin_total - b_begin), 64'd1);
      check({name, " rd_valid count"}, 64'(valid_total - b_valid), 64'(exp_valid));
      check({name, " rd_done count"}, 64'(done_total - b_done), 64'(exp_done));
      check({name, " rd_err count"}, 64'(err_total - b_err), 64'(exp_err));
      check({name, " gnt released"}, 64'(bus.gnt), 64'd0);
      if (exp_done > 0)
         check({name, " done after last valid"}, 64'(done_cyc - last_valid_cyc), 64'd1);
   endtask

   initial begin
      int w;
      int delta;
      int b_done, b_err, b_valid;

      vecs[0] = '{req: 2'b01, sector: 32'h0000_0003, nsend: 512, addr: 32'h0000_0600,
                  exp_valid: 512, exp_done: 1, exp_err: 0};
      vecs[1] = '{req: 2'b10, sector: 32'h0001_2345, nsend: 515, addr: 32'h0246_8A00,
                  exp_valid: 512, exp_done: 1, exp_err: 0};
      vecs[2] = '{req: 2'b01, sector: 32'hFFFF_FFFF, nsend: 100, addr: 32'hFFFF_FE00,
                  exp_valid: 100, exp_done: 0, exp_err: 1};
      vecs[3] = '{req: 2'b10, sector: 32'h0080_0001, nsend: 1, addr: 32'h0000_0200,
                  exp_valid: 1, exp_done: 0, exp_err: 1};

      bus.req = '0; bus.req_sector = '0; bus.sd_idle = 1'b0; bus.sd_active = 1'b0;
      bus.sd_byte_valid = 1'b0; bus.sd_byte = '0;
      tbus.req = '0; tbus.req_sector = '0; tbus.sd_idle = 1'b1; tbus.sd_active = 1'b0;
      tbus.sd_byte_valid = 1'b0; tbus.sd_byte = '0;

      repeat (3) @(negedge clock);
      check("reset outputs", {15'd0, bus.gnt, bus.rd_valid, bus.rd_done, bus.rd_err,
                              bus.sd_begin, bus.sd_addr, bus.rd_byte}, 64'd0);
      reset = 1'b0;
      @(negedge clock);
      check("idle after reset", {bus.gnt, bus.sd_begin, tbus.gnt}, 64'd0);

      for (int i = 0; i < 4; i++) begin
         bus.req_sector = (vecs[i].req == 2'b01) ? {32'h0, vecs[i].sector} : {vecs[i].sector, 32'h0};
         bus.req = vecs[i].req;
         serve(vecs[i].req, vecs[i].addr, vecs[i].nsend, vecs[i].req, vecs[i].exp_valid,
               vecs[i].exp_done, vecs[i].exp_err, $sformatf("vec%0d", i), w);
      end

      bus.req_sector = {32'h7, 32'h5};
      bus.req = 2'b11;
      serve(2'b01, 32'h0000_0A00, 512, 2'b00, 512, 1, 0, "contend r0", w);
      serve(2'b10, 32'h0000_0E00, 8, 2'b10, 8, 0, 1, "contend r1 fair", w);
      serve(2'b01, 32'h0000_0A00, 8, 2'b01, 8, 0, 1, "contend r0 again", w);

      bus.req_sector = {32'h0, 32'h20};
      bus.req = 2'b01;
      begin
         int b_begin;
         b_begin = begin_total;
         repeat (8) @(negedge clock);
         check("busy no begin", 64'(begin_total - b_begin), 64'd0);
         check("busy no gnt", 64'(bus.gnt), 64'd0);
      end
      serve(2'b01, 32'h0000_4000, 16, 2'b01, 16, 0, 1, "busy", w);
      check("busy begin latency", 64'(w >= 1 && w <= 2), 64'd1);

      tbus.req_sector = {32'h0, 32'h5};
      tbus.req = 2'b01;
      w = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (tbus.sd_begin === 1'b1) begin
            w = i;
            break;
         end
      end
      check("timeout begin seen", 64'(w > 0), 64'd1);
      tbus.sd_idle = 1'b0;
      delta = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clock);
         if (|tbus.rd_err) begin
            delta = i;
            break;
         end
      end
      check("timeout err latency", 64'(delta >= 63 && delta <= 67), 64'd1);
      check("timeout err lane", 64'(tbus.rd_err), 64'h1);
      check("timeout gnt released", 64'(tbus.gnt), 64'd0);
      check("timeout no done", 64'(t_done_total), 64'd0);
      tbus.req = '0;
      tbus.sd_idle = 1'b1;

      bus.req_sector = {32'h0, 32'h9};
      bus.req = 2'b01;
      bus.sd_idle = 1'b1;
      exp_lane = 2'b01;
      wait_begin(w);
      check("rst begin seen", 64'(w > 0), 64'd1);
      check("rst sd_addr", 64'(bus.sd_addr), 64'h1200);
      valid_base = valid_total;
      b_valid = valid_total;
      b_done = done_total;
      b_err = err_total;
      bus.sd_active = 1'b1;
      bus.sd_idle = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         bus.sd_byte_valid = 1'b1;
         bus.sd_byte = 8'(i);
      end
      @(negedge clock);
      bus.sd_byte_valid = 1'b0;
      reset = 1'b1;
      bus.req = '0;
      @(negedge clock);
      check("rst outputs cleared", {15'd0, bus.gnt, bus.rd_valid, bus.rd_done, bus.rd_err,
                                    bus.sd_begin, bus.sd_addr, bus.rd_byte}, 64'd0);
      check("rst valid count", 64'(valid_total - b_valid), 64'd200);
      reset = 1'b0;
      bus.sd_active = 1'b0;
      repeat (3) @(negedge clock);
      check("rst no done/err", 64'((done_total - b_done) + (err_total - b_err)), 64'd0);
      bus.req = 2'b01;
      serve(2'b01, 32'h0000_1200, 512, 2'b01, 512, 1, 0, "after reset", w);

      check("data errors", 64'(data_err), 64'd0);
      check("lane errors", 64'(lane_err), 64'd0);
      check("one-hot violations", 64'(multihot), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
